uart_cmd_decoder: RTL
=====================

Name: uart_cmd_decoder

Overview:
- Sits between the uart_rx core and the watch/stopwatch control path inside the watch-UART top.
- Converts each received ASCII byte into the same single-cycle command pulses the debounced board buttons produce, and ORs the two sources.
- Holds the UART-owned mode and edit-field state.
- Echoes each accepted byte, or '?' for a rejected byte, back through uart_tx via a small FIFO and a start/busy handshake.

Parameters:
- FIFO_DEPTH, 4, echo queue depth in entries; power of 2, minimum 2.

Ports:
- clk  input  1  system clock (100 MHz)
- rst  input  1  synchronous active-high reset
- rx_data  input  8  received byte, valid when rx_done=1
- rx_done  input  1  one-cycle strobe from uart_rx
- btnU_up  input  1  debounced one-cycle button pulse
- btnD_down  input  1  debounced one-cycle button pulse
- btnL_clear  input  1  debounced one-cycle button pulse
- btnR_runstop  input  1  debounced one-cycle button pulse
- tx_busy  input  1  uart_tx busy level
- o_up  output  1  increment pulse
- o_down  output  1  decrement pulse
- o_clear  output  1  stopwatch clear pulse
- o_runstop  output  1  stopwatch run/stop toggle pulse
- o_mode  output  1  0 = watch, 1 = stopwatch
- o_field  output  2  edit field: 0 none, 1 hour, 2 min, 3 sec
- tx_data  output  8  echo byte
- tx_start  output  1  one-cycle transmit request
- o_ovf  output  1  sticky echo-FIFO overflow flag

Behaviour:
- Reset: all outputs 0. Mode and field registers are 0. FIFO is empty. Echo FSM is in IDLE.
- Decode happens only when rx_done=1. Letters are case-insensitive.
  - 'M': toggle mode. Field forced to 0 on every toggle. Accepted.
  - '0'..'3': field <= digit. Accepted only in watch mode; otherwise rejected.
  - 'U' / 'D': o_up / o_down pulse. Accepted only in watch mode with field != 0.
  - 'G': o_runstop pulse. Accepted only in stopwatch mode.
  - 'C': o_clear pulse. Accepted only in stopwatch mode.
  - 0x0D and 0x0A: no action and no echo.
  - Any other byte: rejected.
- Accepted byte: its action is taken and the original byte (original case) is pushed to the echo FIFO.
- Rejected byte: no action and no state change; 0x3F ('?') is pushed.
- Latency: the command pulse, mode/field update and FIFO push all occur in the cycle after rx_done (registered, 1 clk).
- Button pulses are registered with the same 1-cycle latency. They pass ungated; the downstream FSM gates them.
- Output pulse = registered button OR registered UART command. Coincident sources produce a single 1-cycle pulse, never 2 cycles.
- Back-to-back rx_done strobes are each decoded; there is no loss as long as the FIFO is not full.
- Echo FIFO: circular, FIFO_DEPTH entries, pointers are log2(FIFO_DEPTH)+1 bits wide.
  - Push while full: byte dropped and o_ovf set. o_ovf clears only on rst.
  - Simultaneous push and pop while full: both occur and no overflow is flagged.
- Echo FSM:
  - IDLE: if FIFO is not empty, pop; tx_data <= head; tx_start=1 for 1 cycle; go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_busy=1, then go to WAIT_DONE. If tx_busy is still 0 after 4 cycles, go to WAIT_DONE anyway (guards against a missed busy edge).
  - WAIT_DONE: wait for tx_busy=0, then return to IDLE.
  - tx_data holds its value from the start pulse until the next start pulse.
  - tx_start is never asserted while tx_busy=1.
- rst mid-transmission: FSM returns to IDLE and the FIFO is flushed. The byte already inside uart_tx is not this block's concern.
- Mode toggle while a stopwatch pulse is in flight: the pulse for the current cycle is still emitted. Gating uses the mode value before the toggle.

Test Plan:
- After rst, send 'M' (0x4D) -> o_mode 0→1 one cycle after rx_done; tx_start pulses once with tx_data=0x4D; o_field=0.
- In watch mode, send '3' then 'U', 'U', 'D' -> o_field=3; exactly two 1-cycle o_up pulses and one o_down pulse; echo sequence 0x33,0x55,0x55,0x44.
- In stopwatch mode, send 'G', 'g', 'C' -> o_runstop pulses twice and o_clear once; echo 0x47,0x67,0x43. Send 'U' -> no o_up; echo 0x3F.
- btnR_runstop and the 'G' decode land in the same cycle -> o_runstop high for exactly 1 cycle.
- Hold tx_busy=1 and inject 6 rx_done bytes back-to-back -> FIFO holds first 4; o_ovf=1. Release tx_busy -> exactly 4 echoes, in order, each tx_start separated by a busy high/low cycle.
- Assert rst while in WAIT_DONE with 2 bytes queued -> all outputs 0 next cycle; no further tx_start after tx_busy falls.

Source files
------------

// File: rtl/uart_cmd_decoder.sv
`default_nettype none
// uart_cmd_decoder: maps received ASCII bytes to button-style command pulses,
// owns the UART mode/field state and echoes bytes back to uart_tx. Rev 1.0
module uart_cmd_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       btnU_up,
  input  logic       btnD_down,
  input  logic       btnL_clear,
  input  logic       btnR_runstop,
  input  logic       tx_busy,
  output logic       o_up,
  output logic       o_down,
  output logic       o_clear,
  output logic       o_runstop,
  output logic       o_mode,
  output logic [1:0] o_field,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       o_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  state_t     r_state, w_next;
  logic [1:0] r_wait_cnt;
  logic       r_up, r_down, r_clear, r_runstop, r_mode, r_ovf, r_tx_start;
  logic [1:0] r_field;
  logic [7:0] r_tx_data;
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW:0] r_wr, r_rd;

  logic [7:0] w_uc;
  logic w_mode_tgl, w_field_wr, w_cmd_up, w_cmd_down, w_cmd_rs, w_cmd_clr;
  logic w_accept, w_silent, w_push, w_do_push, w_pop, w_empty, w_full;
  logic [7:0] w_push_data;

  always_comb begin
    w_uc = rx_data;
    if (rx_data >= 8'h61 && rx_data <= 8'h7A) w_uc = rx_data - 8'h20;
  end

  // Acceptance is judged against the mode/field held before this byte.
  always_comb begin
    w_mode_tgl = 1'b0;
    w_field_wr = 1'b0;
    w_cmd_up   = 1'b0;
    w_cmd_down = 1'b0;
    w_cmd_rs   = 1'b0;
    w_cmd_clr  = 1'b0;
    w_accept   = 1'b0;
    w_silent   = 1'b0;
    case (w_uc)
      8'h4D: begin w_mode_tgl = 1'b1; w_accept = 1'b1; end
      8'h30, 8'h31, 8'h32, 8'h33:
        if (!r_mode) begin w_field_wr = 1'b1; w_accept = 1'b1; end
      8'h55: if (!r_mode && r_field != 2'd0) begin w_cmd_up = 1'b1; w_accept = 1'b1; end
      8'h44: if (!r_mode && r_field != 2'd0) begin w_cmd_down = 1'b1; w_accept = 1'b1; end
      8'h47: if (r_mode) begin w_cmd_rs = 1'b1; w_accept = 1'b1; end
      8'h43: if (r_mode) begin w_cmd_clr = 1'b1; w_accept = 1'b1; end
      8'h0D, 8'h0A: w_silent = 1'b1;
      default: ;
    endcase
  end

  assign w_push      = rx_done & ~w_silent;
  assign w_push_data = w_accept ? rx_data : 8'h3F;
  assign w_empty     = (r_wr == r_rd);
  assign w_full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_push   = w_push & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_up      <= 1'b0;
      r_down    <= 1'b0;
      r_clear   <= 1'b0;
      r_runstop <= 1'b0;
      r_mode    <= 1'b0;
      r_field   <= 2'd0;
    end else begin
      r_up      <= btnU_up      | (rx_done & w_cmd_up);
      r_down    <= btnD_down    | (rx_done & w_cmd_down);
      r_clear   <= btnL_clear   | (rx_done & w_cmd_clr);
      r_runstop <= btnR_runstop | (rx_done & w_cmd_rs);
      if (rx_done && w_mode_tgl) begin
        r_mode  <= ~r_mode;
        r_field <= 2'd0;
      end else if (rx_done && w_field_wr) begin
        r_field <= w_uc[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_ONE;
      if (w_pop)     r_rd <= r_rd + PTR_ONE;
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= 2'd0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_next;
      r_wait_cnt <= (r_state == S_WAIT_BUSY) ? r_wait_cnt + 2'd1 : 2'd0;
      r_tx_start <= w_pop;
      if (w_pop) r_tx_data <= r_mem[r_rd[AW-1:0]];
    end
  end

  // Timeout out of WAIT_BUSY covers a busy pulse that was never observed.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_IDLE:
        if (!w_empty && !tx_busy) begin
          w_pop  = 1'b1;
          w_next = S_WAIT_BUSY;
        end
      S_WAIT_BUSY: if (tx_busy || r_wait_cnt == 2'd3) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (!tx_busy) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  assign o_up      = r_up;
  assign o_down    = r_down;
  assign o_clear   = r_clear;
  assign o_runstop = r_runstop;
  assign o_mode    = r_mode;
  assign o_field   = r_field;
  assign o_ovf     = r_ovf;
  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;

endmodule
`default_nettype wire
